// File: rtl/peripheral_div.sv
// Memory-mapped radix-2 restoring divider. WIDTH iterations per division; software polls STATUS.
// Optional signed division is enabled by defining DIV_SIGNED_EN.
module peripheral_div #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg, q_reg, r_reg;
  logic [WIDTH-1:0]   quo, dvs;
  logic [WIDTH:0]     rem;
  logic [5:0]         cnt;
  logic               done, dbz, busy;

  logic [2:0]         sel;
  logic               wr_en, start, last;
  logic [WIDTH:0]     rem_sh, rem_nxt;
  logic [WIDTH-1:0]   quo_sh, quo_nxt;
  logic               ge;
  logic [WIDTH-1:0]   mag_a, mag_b, q_fin, r_fin;

  // upper data/address bits are intentionally not decoded
  logic unused_bits;
  assign unused_bits = ^{d_in, addr};

  assign sel   = addr[4:2];
  assign wr_en = cs & wr;
  assign start = wr_en && (sel == 3'd2) && d_in[0] && (state == IDLE);
  assign last  = (cnt == CNT_LAST);

  // one restoring step on the working {rem,quo} pair
  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    quo_sh  = {quo[WIDTH-2:0], 1'b0};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
    quo_nxt = quo_sh | WIDTH'(ge);
  end

`ifdef DIV_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign sgn   = d_in[1];
  assign mag_a = (sgn && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign mag_b = (sgn && b_reg[WIDTH-1]) ? -b_reg : b_reg;
  assign q_fin = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      neg_q <= sgn & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
      neg_r <= sgn & a_reg[WIDTH-1];
    end
  end
`else
  assign mag_a = a_reg;
  assign mag_b = b_reg;
  assign q_fin = quo_nxt;
  assign r_fin = rem_nxt[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (b_reg != '0)) state_nxt = RUN;
      RUN:  if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      if (wr_en && sel == 3'd0) a_reg <= d_in[WIDTH-1:0];
      if (wr_en && sel == 3'd1) b_reg <= d_in[WIDTH-1:0];
      if (start) begin
        done <= 1'b0;
        dbz  <= 1'b0;
        if (b_reg == '0) begin
          q_reg <= '1;
          r_reg <= a_reg;
          dbz   <= 1'b1;
          done  <= 1'b1;
        end else begin
          rem <= '0;
          quo <= mag_a;
          dvs <= mag_b;
          cnt <= '0;
        end
      end else if (state == RUN) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 6'd1;
        if (last) begin
          q_reg <= q_fin;
          r_reg <= r_fin;
          done  <= 1'b1;
        end
      end
    end
  end

  // registered read port; holds when not strobed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_out <= '0;
    end else if (cs && rd) begin
      case (sel)
        3'd0:    d_out <= 32'(a_reg);
        3'd1:    d_out <= 32'(b_reg);
        3'd3:    d_out <= 32'(q_reg);
        3'd4:    d_out <= 32'(r_reg);
        3'd5:    d_out <= {29'd0, dbz, busy, done};
        default: d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_div.sv
// Directed bench for peripheral_div (WIDTH=16): vector table plus multi-cycle corner sequences.
module tb_peripheral_div;

  localparam logic [4:0] A_OFS = 5'h00, B_OFS = 5'h04, INIT_OFS = 5'h08,
                         Q_OFS = 5'h0C, R_OFS = 5'h10, ST_OFS = 5'h14;

  logic        clk, resetn, cs, rd, wr;
  logic [31:0] d_in, d_out;
  logic [4:0]  addr;

  int n_tests = 0;
  int n_fail  = 0;

  peripheral_div #(.WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, q, r, st;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  // polls STATUS back-to-back until busy drops; bounded
  task automatic wait_done(output int busy_cnt, output logic [31:0] st);
    busy_cnt = 0;
    st = 32'h2;
    for (int i = 0; i < 60 && st[1]; i++) begin
      rd_reg(ST_OFS, st);
      if (st[1]) busy_cnt++;
    end
    if (st[1]) chk("poll_timeout", st, 32'h1);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] init,
                         output logic [31:0] q, output logic [31:0] r, output logic [31:0] st);
    int bc;
    wr_reg(A_OFS, a);
    wr_reg(B_OFS, b);
    wr_reg(INIT_OFS, init);
    wait_done(bc, st);
    rd_reg(Q_OFS, q);
    rd_reg(R_OFS, r);
  endtask

  initial begin
    logic [31:0] q, r, st, v;
    int bc;

    vecs[0] = '{32'd100,    32'd7,      32'h000E, 32'h0002, 32'h1};
    vecs[1] = '{32'h1234,   32'd0,      32'hFFFF, 32'h1234, 32'h5};
    vecs[2] = '{32'd9,      32'd2,      32'd4,    32'd1,    32'h1};
    vecs[3] = '{32'hFFFF,   32'd1,      32'hFFFF, 32'd0,    32'h1};
    vecs[4] = '{32'hFFFF,   32'hFFFF,   32'd1,    32'd0,    32'h1};
    vecs[5] = '{32'd5,      32'd10,     32'd0,    32'd5,    32'h1};
    vecs[6] = '{32'hFFFF,   32'h10,     32'h0FFF, 32'h000F, 32'h1};
    vecs[7] = '{32'd1000,   32'd10,     32'd100,  32'd0,    32'h1};

    resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    chk("reset_dout", d_out, 32'h0);
    rd_reg(ST_OFS, v); chk("reset_status", v, 32'h0);
    rd_reg(Q_OFS, v);  chk("reset_q", v, 32'h0);

    // busy is visible for exactly WIDTH polls after the start write
    wr_reg(A_OFS, 32'd100);
    wr_reg(B_OFS, 32'd7);
    wr_reg(INIT_OFS, 32'h1);
    wait_done(bc, st);
    chk("busy_cycles", 32'(bc), 32'd16);
    chk("busy_final_status", st, 32'h1);

    // divide by zero finishes on the start edge with no busy
    wr_reg(A_OFS, 32'h1234);
    wr_reg(B_OFS, 32'h0);
    wr_reg(INIT_OFS, 32'h1);
    rd_reg(ST_OFS, v); chk("dbz_status_first", v, 32'h5);

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, 32'h1, q, r, st);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_st", i), st, vecs[i].st);
    end

    // writes and a restart during RUN must not disturb the running division
    wr_reg(A_OFS, 32'd1000);
    wr_reg(B_OFS, 32'd10);
    wr_reg(INIT_OFS, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    wr_reg(A_OFS, 32'd5);
    wr_reg(B_OFS, 32'd1);
    wr_reg(INIT_OFS, 32'h1);
    wait_done(bc, st);
    chk("restart_st", st, 32'h1);
    rd_reg(Q_OFS, q); chk("restart_q", q, 32'd100);
    rd_reg(R_OFS, r); chk("restart_r", r, 32'd0);
    rd_reg(A_OFS, v); chk("restart_a_updated", v, 32'd5);

    // asynchronous reset in the middle of a division
    wr_reg(A_OFS, 32'd50000);
    wr_reg(B_OFS, 32'd3);
    rd_reg(A_OFS, v); chk("pre_reset_a", v, 32'd50000);
    wr_reg(INIT_OFS, 32'h1);
    repeat (8) @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk("async_reset_dout", d_out, 32'h0);
    @(negedge clk) resetn = 1'b1;
    rd_reg(Q_OFS, v);  chk("post_reset_q", v, 32'h0);
    rd_reg(R_OFS, v);  chk("post_reset_r", v, 32'h0);
    rd_reg(ST_OFS, v); chk("post_reset_status", v, 32'h0);
    run_div(32'd9, 32'd2, 32'h1, q, r, st);
    chk("post_reset_q92", q, 32'd4);
    chk("post_reset_r92", r, 32'd1);

`ifdef DIV_SIGNED_EN
    run_div(32'hFF9C, 32'd7, 32'h3, q, r, st);
    chk("signed_q", q, 32'hFFF2);
    chk("signed_r", r, 32'hFFFE);
    run_div(32'h8000, 32'hFFFF, 32'h3, q, r, st);
    chk("signed_ovf_q", q, 32'h8000);
    chk("signed_ovf_r", r, 32'h0);
`endif

    // read latency and hold
    wr_reg(A_OFS, 32'h55);
    wr_reg(B_OFS, 32'hAB);
    rd_reg(A_OFS, v); chk("lat_a", v, 32'h55);
    cs = 1'b1; rd = 1'b1; addr = B_OFS;
    @(negedge clk);
    chk("lat_before_edge", d_out, 32'h55);
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    chk("lat_after_edge", d_out, 32'hAB);
    repeat (3) @(posedge clk);
    #1 chk("lat_hold", d_out, 32'hAB);

    // simultaneous read and write of A returns the old value
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_OFS; d_in = 32'h77;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("rw_same_old", d_out, 32'h55);
    rd_reg(A_OFS, v); chk("rw_same_new", v, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
